// File: rtl/ppu_requant_pp.sv
// ppu_requant_pp: requantise accumulator rows and transpose ping-pong tiles.
// Ports: clk, rst (sync, active-high), cfg_mult/cfg_shift/cfg_relu,
//   in_valid/in_ready/acc_in (one row per beat, rows in reverse order),
//   out_valid/out_ready/out_data/out_col/out_last (one column per beat),
//   busy. With PPU_SAT_FLAG_EN defined: sat_clr in, sticky sat_flag out.
module ppu_requant_pp #(
    parameter int ARRAY_SIZE  = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [MULT_WIDTH-1:0]        cfg_mult,
    input  logic        [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic                                cfg_relu,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]     acc_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0]     out_data,
    output logic [$clog2(ARRAY_SIZE)-1:0]       out_col,
    output logic                                out_last,
`ifdef PPU_SAT_FLAG_EN
    input  logic                                sat_clr,
    output logic                                sat_flag,
`endif
    output logic                                busy
);

    localparam int N  = ARRAY_SIZE;
    localparam int CW = $clog2(ARRAY_SIZE);
    localparam int PW = ACC_WIDTH + MULT_WIDTH;
    localparam int OW = OUT_WIDTH;

    localparam logic [CW-1:0] LASTI = CW'(N - 1);
    localparam logic signed [PW-1:0] OMAX =
        {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [PW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_st_t;

    bank_st_t st_q [2];
    bank_st_t st_d [2];

    logic          wr_bank, wr_bank_d;
    logic          rd_bank, rd_bank_d;
    logic [CW-1:0] row_cnt, row_cnt_d;
    logic [CW-1:0] wr_row;

    logic signed [MULT_WIDTH-1:0] mult_q;
    logic [SHIFT_WIDTH-1:0]       shift_q;
    logic                         relu_q;

    logic signed [MULT_WIDTH-1:0] e_mult;
    logic [SHIFT_WIDTH-1:0]       e_shift;
    logic                         e_relu;

    logic [OW-1:0] mem [2][N][N];

    logic signed [PW-1:0] pre [N];
    logic [OW-1:0]        rq  [N];

    logic first, cap, last_row, take, fin;
    logic nb, ld, ld_new, ld_bank;
    logic [CW-1:0]   ld_col;
    logic [N*OW-1:0] col_dat;

    // Multiply, round half up, optional ReLU; clamping happens later.
    function automatic logic signed [PW-1:0] rq_pre(
        input logic [ACC_WIDTH-1:0]   a,
        input logic [MULT_WIDTH-1:0]  m,
        input logic [SHIFT_WIDTH-1:0] s,
        input logic                   relu
    );
        logic signed [PW-1:0] ax, mx, p, rnd;
        ax = {{MULT_WIDTH{a[ACC_WIDTH-1]}}, a};
        mx = {{ACC_WIDTH{m[MULT_WIDTH-1]}}, m};
        p  = ax * mx;
        rnd = '0;
        if (s != '0)
            rnd = {{(PW-1){1'b0}}, 1'b1} << (s - 1'b1);
        p = (p + rnd) >>> s;
        if (relu && p[PW-1])
            p = '0;
        return p;
    endfunction

    function automatic logic [OW-1:0] clamp(
        input logic signed [PW-1:0] v
    );
        if (v > OMAX)
            return OMAX[OW-1:0];
        else if (v < OMIN)
            return OMIN[OW-1:0];
        else
            return v[OW-1:0];
    endfunction

    assign first    = (row_cnt == '0);
    assign wr_row   = LASTI - row_cnt;
    assign in_ready = (st_q[wr_bank] == EMPTY) ||
                      (st_q[wr_bank] == FILLING);
    assign cap      = in_valid && in_ready;
    assign last_row = cap && (row_cnt == LASTI);
    assign take     = out_valid && out_ready;
    assign fin      = take && out_last;
    assign busy     = (st_q[0] != EMPTY) || (st_q[1] != EMPTY);

    // Beat 0 uses the live config; later beats use the latched copy.
    assign e_mult  = first ? cfg_mult  : mult_q;
    assign e_shift = first ? cfg_shift : shift_q;
    assign e_relu  = first ? cfg_relu  : relu_q;

    always_comb begin
        for (int c = 0; c < N; c++) begin
            pre[c] = rq_pre(acc_in[c*ACC_WIDTH +: ACC_WIDTH],
                            e_mult, e_shift, e_relu);
            rq[c]  = clamp(pre[c]);
        end
    end

    // Pick the next column to present. A bank finishing its last row
    // this cycle is drained straight away, so row (wr_row) comes from
    // the incoming data instead of the array.
    always_comb begin
        nb      = fin ? ~rd_bank : rd_bank;
        ld      = 1'b0;
        ld_new  = 1'b0;
        ld_bank = rd_bank;
        ld_col  = '0;
        if (take && !out_last) begin
            ld     = 1'b1;
            ld_col = out_col + CW'(1);
        end else if (!out_valid || fin) begin
            ld_bank = nb;
            ld_new  = (st_q[nb] == FULL) ||
                      (last_row && (wr_bank == nb));
            ld      = ld_new;
        end
        for (int r = 0; r < N; r++) begin
            if (cap && (wr_bank == ld_bank) && (wr_row == CW'(r)))
                col_dat[r*OW +: OW] = rq[ld_col];
            else
                col_dat[r*OW +: OW] = mem[ld_bank][r][ld_col];
        end
    end

    always_comb begin
        st_d      = st_q;
        wr_bank_d = wr_bank;
        rd_bank_d = rd_bank;
        row_cnt_d = row_cnt;
        if (cap) begin
            if (first)
                st_d[wr_bank] = FILLING;
            if (last_row) begin
                st_d[wr_bank] = FULL;
                wr_bank_d     = ~wr_bank;
                row_cnt_d     = '0;
            end else begin
                row_cnt_d = row_cnt + CW'(1);
            end
        end
        if (fin) begin
            st_d[rd_bank] = EMPTY;
            rd_bank_d     = ~rd_bank;
        end
        if (ld_new)
            st_d[ld_bank] = DRAINING;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            row_cnt   <= '0;
            mult_q    <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            st_q    <= st_d;
            wr_bank <= wr_bank_d;
            rd_bank <= rd_bank_d;
            row_cnt <= row_cnt_d;
            if (cap && first) begin
                mult_q  <= cfg_mult;
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end
            if (ld) begin
                out_valid <= 1'b1;
                out_data  <= col_dat;
                out_col   <= ld_col;
                out_last  <= (ld_col == LASTI);
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap && !rst) begin
            for (int c = 0; c < N; c++)
                mem[wr_bank][wr_row][c] <= rq[c];
        end
    end

`ifdef PPU_SAT_FLAG_EN
    logic [N-1:0] sat_vec;

    always_comb begin
        for (int c = 0; c < N; c++)
            sat_vec[c] = (pre[c] > OMAX) || (pre[c] < OMIN);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (cap && (|sat_vec))
            sat_flag <= 1'b1;
        else if (sat_clr)
            sat_flag <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ppu_requant_pp.sv
// tb_ppu_requant_pp: directed vector bench for ppu_requant_pp.
// Covers identity transpose, requant table, backpressure, streaming, reset.
module tb_ppu_requant_pp;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int MW = 16;
    localparam int SW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [MW-1:0]      cfg_mult;
    logic [SW-1:0]      cfg_shift;
    logic               cfg_relu;
    logic               in_valid;
    logic               in_ready;
    logic [N*AW-1:0]    acc_in;
    logic               out_valid;
    logic               out_ready;
    logic [N*OW-1:0]    out_data;
    logic [1:0]         out_col;
    logic               out_last;
    logic               busy;
`ifdef PPU_SAT_FLAG_EN
    logic               sat_clr;
    logic               sat_flag;
`endif

    always #5 clk = ~clk;

    ppu_requant_pp #(
        .ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
        .MULT_WIDTH(MW), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_col(out_col), .out_last(out_last),
`ifdef PPU_SAT_FLAG_EN
        .sat_clr(sat_clr), .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] acc;
        logic [MW-1:0] mult;
        logic [SW-1:0] shift;
        logic          relu;
        logic [OW-1:0] exp;
        logic          sat;
    } vec_t;

    typedef struct {
        logic [N*OW-1:0] data;
        logic [1:0]      col;
        logic            last;
        int              cyc;
    } col_t;

    vec_t vt [14];
    col_t colq [$];
    int   rowq [$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   ir_drop = 0;
    bit   watch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready)
                colq.push_back('{out_data, out_col, out_last, cyc});
            if (in_valid && in_ready)
                rowq.push_back(cyc);
            if (watch && !in_ready)
                ir_drop++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] mkrow(input int k, input int add);
        logic [N*AW-1:0] r;
        for (int c = 0; c < N; c++)
            r[c*AW +: AW] = AW'((N-1-k)*10 + c + add);
        return r;
    endfunction

    function automatic logic [N*OW-1:0] mkcol(input int c, input int add,
                                              input int m);
        logic [N*OW-1:0] v;
        for (int r = 0; r < N; r++)
            v[r*OW +: OW] = OW'((r*10 + c + add) * m);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [N*AW-1:0] row);
        int t = 0;
        in_valid = 1'b1;
        acc_in   = row;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL send_row: in_ready stuck at 0");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cols(input int n, input string nm);
        int t = 0;
        while (colq.size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (colq.size() < n) begin
            nvec++;
            nerr++;
            $display("FAIL %s: got %0d columns want %0d",
                     nm, colq.size(), n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{32'd5,          16'd3,       5'd2,  1'b0, 16'd4,      1'b0};
        vt[1]  = '{-32'sd5,        16'd3,       5'd2,  1'b0, 16'hFFFC,   1'b0};
        vt[2]  = '{32'd6,          16'd1,       5'd2,  1'b0, 16'd2,      1'b0};
        vt[3]  = '{32'd7,          16'd1,       5'd1,  1'b0, 16'd4,      1'b0};
        vt[4]  = '{-32'sd7,        16'd1,       5'd1,  1'b0, 16'hFFFD,   1'b0};
        vt[5]  = '{32'd1000,       16'hFFFD,    5'd0,  1'b0, 16'hF448,   1'b0};
        vt[6]  = '{-32'sd3,        16'hFFFD,    5'd0,  1'b1, 16'd9,      1'b0};
        vt[7]  = '{-32'sd7,        16'd1,       5'd0,  1'b1, 16'd0,      1'b0};
        vt[8]  = '{32'd65536,      16'h8000,    5'd16, 1'b0, 16'h8000,   1'b0};
        vt[9]  = '{32'h7FFFFFFF,   16'h7FFF,    5'd31, 1'b0, 16'h7FFF,   1'b0};
        vt[10] = '{-32'sd100000,   16'd1,       5'd0,  1'b0, 16'h8000,   1'b1};
        vt[11] = '{32'd100000,     16'd1,       5'd0,  1'b0, 16'h7FFF,   1'b1};
        vt[12] = '{-32'sd100000,   16'd1,       5'd0,  1'b1, 16'd0,      1'b0};
        vt[13] = '{32'h80000000,   16'h8000,    5'd0,  1'b0, 16'h7FFF,   1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        acc_in    = '0;
        out_ready = 1'b0;
        cfg_mult  = 16'd1;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
`ifdef PPU_SAT_FLAG_EN
        sat_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
`ifdef PPU_SAT_FLAG_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif
        step();

        // identity transpose
        out_ready = 1'b1;
        colq.delete();
        rowq.delete();
        for (int k = 0; k < N; k++)
            send_row(mkrow(k, 0));
        wait_cols(4, "id_cols");
        chk("id_rows", rowq.size(), 4);
        for (int i = 0; i < colq.size(); i++) begin
            chk($sformatf("id_data%0d", i), colq[i].data, mkcol(i, 0, 1));
            chk($sformatf("id_col%0d", i), colq[i].col, i);
            chk($sformatf("id_last%0d", i), colq[i].last, (i == 3));
        end
        if (colq.size() == 4 && rowq.size() == 4) begin
            chk("id_latency", colq[0].cyc, rowq[3] + 1);
            chk("id_consec", colq[3].cyc - colq[0].cyc, 3);
        end

        // requant vector table
        for (int v = 0; v < 14; v++) begin
            cfg_mult  = vt[v].mult;
            cfg_shift = vt[v].shift;
            cfg_relu  = vt[v].relu;
`ifdef PPU_SAT_FLAG_EN
            sat_clr = 1'b1;
            step();
            sat_clr = 1'b0;
`endif
            colq.delete();
            for (int k = 0; k < N; k++)
                send_row({N{vt[v].acc}});
            wait_cols(4, $sformatf("vec%0d_cols", v));
            if (colq.size() == 4) begin
                chk($sformatf("vec%0d_c0", v), colq[0].data, {N{vt[v].exp}});
                chk($sformatf("vec%0d_c3", v), colq[3].data, {N{vt[v].exp}});
            end
`ifdef PPU_SAT_FLAG_EN
            @(negedge clk);
            chk($sformatf("vec%0d_sat", v), sat_flag, vt[v].sat);
            step();
`endif
        end
`ifdef PPU_SAT_FLAG_EN
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr", sat_flag, 0);
        step();
`endif
        cfg_mult  = 16'd1;
        cfg_shift = '0;
        cfg_relu  = 1'b0;

        // backpressure: 9 rows offered, 8 fit
        out_ready = 1'b0;
        colq.delete();
        rowq.delete();
        for (int k = 0; k < 8; k++)
            send_row(mkrow(k % 4, (k < 4) ? 0 : 100));
        in_valid = 1'b1;
        acc_in   = mkrow(0, 500);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_col", out_col, 0);
        chk("bp_data", out_data, mkcol(0, 0, 1));
        repeat (5) @(negedge clk);
        chk("bp_hold_data", out_data, mkcol(0, 0, 1));
        chk("bp_hold_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_rows", rowq.size(), 8);
        out_ready = 1'b1;
        wait_cols(8, "bp_cols");
        for (int i = 0; i < colq.size(); i++) begin
            chk($sformatf("bp_data%0d", i), colq[i].data,
                mkcol(i % 4, (i < 4) ? 0 : 100, 1));
            chk($sformatf("bp_col%0d", i), colq[i].col, i % 4);
        end
        @(negedge clk);
        chk("bp_ready_again", in_ready, 1);
        step();

        // back-to-back, cfg_mult changed on beat 2 of each tile
        colq.delete();
        rowq.delete();
        ir_drop = 0;
        watch   = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < N; k++) begin
                cfg_mult = MW'((k < 2) ? t + 1 : t + 2);
                send_row(mkrow(k, t));
            end
        end
        watch = 1'b0;
        wait_cols(12, "b2b_cols");
        chk("b2b_rows", rowq.size(), 12);
        chk("b2b_in_ready_drop", ir_drop, 0);
        if (rowq.size() == 12)
            chk("b2b_row_span", rowq[11] - rowq[0], 11);
        for (int i = 0; i < colq.size(); i++)
            chk($sformatf("b2b_data%0d", i), colq[i].data,
                mkcol(i % 4, i / 4, i / 4 + 1));
        if (colq.size() == 12 && rowq.size() == 12) begin
            chk("b2b_col_span", colq[11].cyc - colq[0].cyc, 11);
            chk("b2b_latency", colq[0].cyc, rowq[3] + 1);
        end
        cfg_mult = 16'd1;

        // reset in the middle of a tile
        send_row(mkrow(0, 900));
        send_row(mkrow(1, 900));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        step();
        colq.delete();
        rowq.delete();
        for (int k = 0; k < N; k++)
            send_row(mkrow(k, 0));
        wait_cols(4, "mid_rst_cols");
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_ncols", colq.size(), 4);
        for (int i = 0; i < colq.size(); i++)
            chk($sformatf("mid_rst_data%0d", i), colq[i].data,
                mkcol(i, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
